vga_fetch_arbiter: RTL

Single-port arbiter in front of the VGA sprite/tile RAM inside the `soc_system` display peripheral. It shares one synchronous single-port RAM between two requesters: the scanout fetch engine, which has priority so active video never stalls, and HPS Avalon-MM writes, which are held in a one-entry buffer. A bounded-wait guard forces a write slot after a fixed number of denied cycles. A saturating stall counter is exposed for driver diagnostics.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_fetch_arbiter_if.sv | 44 ++++
 rtl/sat_counter.sv | 36 +++
 rtl/vga_fetch_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default widths for the VGA sprite/tile RAM arbiter and scanout engine.
package vga_pkg;

  localparam int unsigned VGA_ADDR_W = 12;
  localparam int unsigned VGA_DATA_W = 32;
  localparam int unsigned WAIT_W     = 8;
  localparam int unsigned STALL_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2
  } grant_state_t;

  // Value of the wait counter on the cycle a buffered write must be forced.
  function automatic logic [WAIT_W-1:0] wait_limit(input int unsigned max_wait);
    return WAIT_W'(max_wait - 1);
  endfunction

endpackage

// File: rtl/vga_fetch_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (Avalon writes, scanout fetch) and the RAM.
interface vga_fetch_arbiter_if #(
  parameter int unsigned ADDR_W = vga_pkg::VGA_ADDR_W,
  parameter int unsigned DATA_W = vga_pkg::VGA_DATA_W
);

  logic              avs_chipselect;
  logic              avs_write;
  logic [ADDR_W-1:0] avs_address;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_waitrequest;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  avs_chipselect, avs_write, avs_address, avs_writedata,
    input  fetch_req, fetch_addr,
    input  ram_rdata,
    output avs_waitrequest,
    output fetch_gnt, fetch_rvalid, fetch_rdata,
    output ram_addr, ram_we, ram_wdata
  );

  // Requesters and RAM side
  modport master (
    output avs_chipselect, avs_write, avs_address, avs_writedata,
    output fetch_req, fetch_addr,
    output ram_rdata,
    input  avs_waitrequest,
    input  fetch_gnt, fetch_rvalid, fetch_rdata,
    input  ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear and reset.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_VAL)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_fetch_arbiter.sv
// Shares one single-port sprite/tile RAM between scanout fetches (priority) and a
// one-entry buffered Avalon write path with a bounded-wait forcing guard.
module vga_fetch_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W   = VGA_ADDR_W,
  parameter int unsigned DATA_W   = VGA_DATA_W,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  vga_fetch_arbiter_if.slave bus,
  output logic [STALL_W-1:0] stall_count
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = wait_limit(MAX_WAIT);

  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q,  buf_addr_d;
  logic [DATA_W-1:0] buf_data_q,  buf_data_d;
  logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
  grant_state_t      state_q,     state_d;

  logic              fetch_gnt_c;
  logic              wr_gnt_c;
  logic              waitreq_c;
  logic              accept_c;
  logic              stall_inc_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic              ram_we_c;

  // Grant priority: forced write, then fetch, then opportunistic write. Nothing
  // reaches the RAM while reset is held so a buffered write is truly discarded.
  always_comb begin
    fetch_gnt_c = 1'b0;
    wr_gnt_c    = 1'b0;
    if (!reset) begin
      if (buf_valid_q && (wait_cnt_q == WAIT_LAST)) begin
        wr_gnt_c = 1'b1;
      end else if (bus.fetch_req) begin
        fetch_gnt_c = 1'b1;
      end else if (buf_valid_q) begin
        wr_gnt_c = 1'b1;
      end
    end
  end

  always_comb begin
    waitreq_c   = buf_valid_q & ~wr_gnt_c;
    accept_c    = bus.avs_chipselect & bus.avs_write & ~waitreq_c;
    stall_inc_c = buf_valid_q & ~wr_gnt_c;
  end

  // Write buffer: a drain and a new accept in the same cycle leave it full.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (wr_gnt_c) begin
      buf_valid_d = 1'b0;
    end
    if (accept_c) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = bus.avs_address;
      buf_data_d  = bus.avs_writedata;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    if (!buf_valid_q || wr_gnt_c) begin
      wait_cnt_d = '0;
    end
  end

  always_comb begin
    ram_addr_c = '0;
    ram_we_c   = 1'b0;
    if (fetch_gnt_c) begin
      ram_addr_c = bus.fetch_addr;
    end else if (wr_gnt_c) begin
      ram_addr_c = buf_addr_q;
      ram_we_c   = 1'b1;
    end
  end

  // Grant FSM remembers last cycle's grant to qualify the RAM read data.
  always_comb begin
    state_d = S_IDLE;
    if (fetch_gnt_c) begin
      state_d = S_FETCH;
    end else if (wr_gnt_c) begin
      state_d = S_WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      buf_valid_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

  sat_counter #(
    .WIDTH (STALL_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_c),
    .clr   (1'b0),
    .count (stall_count)
  );

  assign bus.avs_waitrequest = waitreq_c;
  assign bus.fetch_gnt       = fetch_gnt_c;
  assign bus.fetch_rvalid    = (state_q == S_FETCH);
  assign bus.fetch_rdata     = bus.ram_rdata;
  assign bus.ram_addr        = ram_addr_c;
  assign bus.ram_we          = ram_we_c;
  assign bus.ram_wdata       = buf_data_q;

endmodule
